// File: rtl/result_pack.sv
// result_pack: collects 16/8-bit lane results into 64-bit words and issues them as sequential RAM writes.
// Define PACK_MASK_EN to add the wr_be byte-enable output for partial words.
module result_pack #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pos,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       lane_0,
    input  logic [15:0]       lane_1,
    input  logic [15:0]       lane_2,
    input  logic [15:0]       lane_3,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
`ifdef PACK_MASK_EN
    output logic [7:0]        wr_be,
`endif
    output logic              done
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned SLOT_W = 3;
`ifdef PACK_MASK_EN
    localparam int unsigned BE_W   = 8;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        M_WIDE   = 2'b00,
        M_LANE16 = 2'b01,
        M_LANE8  = 2'b10
    } mode_t;

    state_t              state;
    mode_t               mode_q;
    logic [SLOT_W-1:0]   slot;
    logic [WORD_W-1:0]   asm_q;

    logic                accept;
    logic                out_free;
    logic                word_done;
    logic [WORD_W-1:0]   asm_nx;
    logic [SLOT_W-1:0]   slot_nx;

    assign in_ready = (state == S_RUN) && (!wr_en || wr_ready);
    assign accept   = in_valid && in_ready;
    // Output register can take a new word this edge (empty, or its write is being accepted).
    assign out_free = !wr_en || wr_ready;

    // Merge the current beat into the assembly word.
    always_comb begin
        asm_nx    = asm_q;
        slot_nx   = slot;
        word_done = 1'b0;
        case (mode_q)
            M_LANE16: begin
                asm_nx[{slot[1:0], 4'd0} +: 16] = lane_0;
                word_done = (slot[1:0] == 2'd3);
                slot_nx   = slot + SLOT_W'(1);
            end
            M_LANE8: begin
                asm_nx[{slot, 3'd0} +: 8] = lane_0[7:0];
                word_done = (slot == 3'd7);
                slot_nx   = slot + SLOT_W'(1);
            end
            default: begin
                asm_nx    = {lane_3, lane_2, lane_1, lane_0};
                word_done = 1'b1;
                slot_nx   = '0;
            end
        endcase
    end

`ifdef PACK_MASK_EN
    logic [BE_W-1:0] be_part;

    // Byte enables covering only the filled slots of a partial word.
    always_comb begin
        be_part = '0;
        for (int i = 0; i < 8; i++) begin
            if (mode_q == M_LANE8) begin
                be_part[i] = (SLOT_W'(i) < slot);
            end else begin
                be_part[i] = (SLOT_W'(i / 2) < slot);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            mode_q  <= M_WIDE;
            slot    <= '0;
            asm_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
`ifdef PACK_MASK_EN
            wr_be   <= '0;
`endif
            done    <= 1'b0;
        end else if (start_pos) begin
            // New job: drop any pending write and partial assembly.
            state   <= S_RUN;
            mode_q  <= (mode == 2'b11) ? M_WIDE : mode_t'(mode);
            slot    <= '0;
            asm_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= base_addr;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en && wr_ready) begin
                wr_en   <= 1'b0;
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_RUN: begin
                    if (accept) begin
                        if (word_done) begin
                            wr_en   <= 1'b1;
                            wr_data <= asm_nx;
`ifdef PACK_MASK_EN
                            wr_be   <= 8'hFF;
`endif
                            slot    <= '0;
                            asm_q   <= '0;
                        end else begin
                            slot  <= slot_nx;
                            asm_q <= asm_nx;
                        end
                    end
                    if (flush) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (slot == '0) begin
                        state <= S_DRAIN;
                    end else if (out_free) begin
                        wr_en   <= 1'b1;
                        wr_data <= asm_q;
`ifdef PACK_MASK_EN
                        wr_be   <= be_part;
`endif
                        slot    <= '0;
                        asm_q   <= '0;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_free) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_pack.sv
// Directed-vector bench for result_pack; a second ADDR_W=4 instance shares the stimulus to show address wrap.
module tb_result_pack;

    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_pos;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic              flush;
    logic              in_valid;
    logic              wr_ready;
    logic [15:0]       lane_0, lane_1, lane_2, lane_3;

    logic              in_ready, wr_en, done;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic              in_ready4, wr_en4, done4;
    logic [3:0]        wr_addr4;
    logic [63:0]       wr_data4;
`ifdef PACK_MASK_EN
    logic [7:0]        wr_be, wr_be4;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_done4 = 0;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [63:0]       wq_data[$];
    logic [3:0]        wq4_addr[$];
    logic [63:0]       wq4_data[$];

    result_pack #(.ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst(rst), .start_pos(start_pos), .mode(mode), .base_addr(base_addr),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .lane_0(lane_0), .lane_1(lane_1), .lane_2(lane_2), .lane_3(lane_3),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PACK_MASK_EN
        .wr_be(wr_be),
`endif
        .done(done)
    );

    result_pack #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_pos(start_pos), .mode(mode), .base_addr(base_addr[3:0]),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .lane_0(lane_0), .lane_1(lane_1), .lane_2(lane_2), .lane_3(lane_3),
        .wr_en(wr_en4), .wr_ready(wr_ready), .wr_addr(wr_addr4), .wr_data(wr_data4),
`ifdef PACK_MASK_EN
        .wr_be(wr_be4),
`endif
        .done(done4)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (!rst && !start_pos) begin
            if (wr_en && wr_ready) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
            end
            if (wr_en4 && wr_ready) begin
                wq4_addr.push_back(wr_addr4);
                wq4_data.push_back(wr_data4);
            end
            if (done)  n_done++;
            if (done4) n_done4++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [1:0] m, input logic [ADDR_W-1:0] b);
        start_pos = 1'b1;
        mode      = m;
        base_addr = b;
        tick();
        start_pos = 1'b0;
    endtask

    task automatic beat(input logic [15:0] l0, input logic [15:0] l1,
                        input logic [15:0] l2, input logic [15:0] l3);
        int n = 0;
        in_valid = 1'b1;
        lane_0 = l0; lane_1 = l1; lane_2 = l2; lane_3 = l3;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("beat_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        int n = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(done), 64'd1);
        tick();
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int q0;
        rst = 1'b1; start_pos = 1'b0; mode = 2'b00; base_addr = '0; flush = 1'b0;
        in_valid = 1'b0; wr_ready = 1'b1;
        lane_0 = '0; lane_1 = '0; lane_2 = '0; lane_3 = '0;
        tick();
        tick();
        chk("rst_wr_en",    64'(wr_en),    64'd0);
        chk("rst_wr_addr",  64'(wr_addr),  64'd0);
        chk("rst_wr_data",  wr_data,       64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_in_ready4", 64'(in_ready4), 64'd0);
        rst = 1'b0;
        tick();

        // WIDE, back-to-back, one write per beat with latency 1
        q0 = wq_addr.size();
        start_job(2'b00, 9'h010);
        beat(16'd1, 16'd2, 16'd3, 16'd4);
        chk("w1_en",   64'(wr_en),   64'd1);
        chk("w1_addr", 64'(wr_addr), 64'h010);
        chk("w1_data", wr_data,      64'h0004_0003_0002_0001);
        beat(16'd5, 16'd6, 16'd7, 16'd8);
        chk("w2_en",   64'(wr_en),   64'd1);
        chk("w2_addr", 64'(wr_addr), 64'h011);
        chk("w2_data", wr_data,      64'h0008_0007_0006_0005);
        tick();
        chk("w_idle_en",   64'(wr_en),   64'd0);
        chk("w_next_addr", 64'(wr_addr), 64'h012);
        chk("w_nwrites", 64'(wq_addr.size() - q0), 64'd2);
        finish_job("w_done");

        // LANE16: no write until the 4th beat
        start_job(2'b01, 9'h020);
        beat(16'hAAAA, 16'h0, 16'h0, 16'h0);
        chk("l16_b1_en", 64'(wr_en), 64'd0);
        beat(16'hBBBB, 16'h0, 16'h0, 16'h0);
        chk("l16_b2_en", 64'(wr_en), 64'd0);
        beat(16'hCCCC, 16'h0, 16'h0, 16'h0);
        chk("l16_b3_en", 64'(wr_en), 64'd0);
        beat(16'hDDDD, 16'h0, 16'h0, 16'h0);
        chk("l16_en",   64'(wr_en),   64'd1);
        chk("l16_addr", 64'(wr_addr), 64'h020);
        chk("l16_data", wr_data,      64'hDDDD_CCCC_BBBB_AAAA);
`ifdef PACK_MASK_EN
        chk("l16_be", 64'(wr_be), 64'hFF);
`endif
        finish_job("l16_done");

        // LANE8 partial word via flush; done exactly one cycle after the write
        start_job(2'b10, 9'h030);
        beat(16'h0011, 16'h0, 16'h0, 16'h0);
        beat(16'h0022, 16'h0, 16'h0, 16'h0);
        beat(16'h0033, 16'h0, 16'h0, 16'h0);
        chk("l8_pre_en", 64'(wr_en), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("l8_en",   64'(wr_en),   64'd1);
        chk("l8_addr", 64'(wr_addr), 64'h030);
        chk("l8_data", wr_data,      64'h0000_0000_0033_2211);
        chk("l8_done_early", 64'(done), 64'd0);
`ifdef PACK_MASK_EN
        chk("l8_be", 64'(wr_be), 64'h07);
`endif
        tick();
        chk("l8_en_drop", 64'(wr_en), 64'd0);
        chk("l8_done",    64'(done),  64'd1);
        tick();
        chk("l8_done_once", 64'(done), 64'd0);

        // WIDE with 5 cycles of write backpressure
        q0 = wq_addr.size();
        wr_ready = 1'b0;
        start_job(2'b11, 9'h040);
        beat(16'hA0, 16'hA1, 16'hA2, 16'hA3);
        in_valid = 1'b1;
        lane_0 = 16'hB0; lane_1 = 16'hB1; lane_2 = 16'hB2; lane_3 = 16'hB3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_en",       64'(wr_en),    64'd1);
            chk("bp_addr",     64'(wr_addr),  64'h040);
            chk("bp_data",     wr_data,       64'h00A3_00A2_00A1_00A0);
            tick();
        end
        wr_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp2_en",   64'(wr_en),   64'd1);
        chk("bp2_addr", 64'(wr_addr), 64'h041);
        chk("bp2_data", wr_data,      64'h00B3_00B2_00B1_00B0);
        tick();
        chk("bp_idle_en", 64'(wr_en), 64'd0);
        chk("bp_nwrites", 64'(wq_addr.size() - q0), 64'd2);
        chk("bp_q0_addr", 64'(wq_addr[q0]),     64'h040);
        chk("bp_q0_data", wq_data[q0],          64'h00A3_00A2_00A1_00A0);
        chk("bp_q1_addr", 64'(wq_addr[q0 + 1]), 64'h041);
        chk("bp_q1_data", wq_data[q0 + 1],      64'h00B3_00B2_00B1_00B0);
        finish_job("bp_done");

        // Address wrap on the 4-bit instance
        q0 = wq4_addr.size();
        start_job(2'b00, 9'h00F);
        beat(16'h1, 16'h0, 16'h0, 16'h0);
        beat(16'h2, 16'h0, 16'h0, 16'h0);
        beat(16'h3, 16'h0, 16'h0, 16'h0);
        tick();
        chk("wrap_nwrites", 64'(wq4_addr.size() - q0), 64'd3);
        chk("wrap_a0", 64'(wq4_addr[q0]),     64'hF);
        chk("wrap_a1", 64'(wq4_addr[q0 + 1]), 64'h0);
        chk("wrap_a2", 64'(wq4_addr[q0 + 2]), 64'h1);
        chk("wrap_d2", wq4_data[q0 + 2],      64'h3);
        finish_job("wrap_done");

        // LANE16 partial discarded by start_pos; new job writes a clean word
        q0 = wq_addr.size();
        start_job(2'b01, 9'h050);
        beat(16'h1111, 16'h0, 16'h0, 16'h0);
        beat(16'h2222, 16'h0, 16'h0, 16'h0);
        start_job(2'b01, 9'h060);
        chk("sp_no_write", 64'(wq_addr.size() - q0), 64'd0);
        beat(16'h3333, 16'h0, 16'h0, 16'h0);
        beat(16'h4444, 16'h0, 16'h0, 16'h0);
        beat(16'h5555, 16'h0, 16'h0, 16'h0);
        beat(16'h6666, 16'h0, 16'h0, 16'h0);
        chk("sp_addr", 64'(wr_addr), 64'h060);
        chk("sp_data", wr_data,      64'h6666_5555_4444_3333);
        finish_job("sp_done");
        chk("sp_nwrites", 64'(wq_addr.size() - q0), 64'd1);

        // LANE16 partial discarded by reset
        q0 = wq_addr.size();
        start_job(2'b01, 9'h070);
        beat(16'h7777, 16'h0, 16'h0, 16'h0);
        beat(16'h8888, 16'h0, 16'h0, 16'h0);
        rst = 1'b1;
        #1;
        chk("rm_en",       64'(wr_en),    64'd0);
        chk("rm_addr",     64'(wr_addr),  64'd0);
        chk("rm_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("rm_no_write", 64'(wq_addr.size() - q0), 64'd0);
        chk("rm_no_done",  64'(done), 64'd0);

        chk("n_done",  64'(n_done),  64'd6);
        chk("n_done4", 64'(n_done4), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
